gpu_bg_block_mem: RTL and testbench

Background-block memory sequencer between the GPU pixel backend and the VRAM/DDR arbiter. On each block-transition code raised by the backend, it writes back the finished 16-pixel (256-bit) block using per-pixel write masks. It then reads the next block, hands it to the backend in a single cycle, and drives the pause and reset handshakes that freeze and re-arm the pixel pipeline.

---
 rtl/gpu_bg_pkg.sv | 55 +++++
 rtl/gpu_bg_block_mem.sv | 200 ++++++++++++++++++++
 tb/tb_gpu_bg_block_mem.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_bg_pkg.sv
// Shared definitions for the background-block memory sequencer.
//   - bg_state_e   : sequencer state encoding
//   - BG_*         : backend pair codes carried on i_saveBGBlock
//   - BG_BEATS     : 32-bit beats per 16-pixel block
//   - next_beat()  : finds the next beat whose pixel-pair mask is nonzero
//   - beat_word()/beat_mask() : slice one beat out of a block / mask
package gpu_bg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrBeat,
        StRdReq,
        StRdData,
        StCommit,
        StRelease,
        StHold
    } bg_state_e;

    localparam logic [1:0] BG_NONE  = 2'b00;
    localparam logic [1:0] BG_FIRST = 2'b01;
    localparam logic [1:0] BG_NEXT  = 2'b10;
    localparam logic [1:0] BG_FLUSH = 2'b11;

    localparam int BG_BEATS = 8;

    typedef struct packed {
        logic       done;  // no further beat with a nonzero mask pair
        logic [2:0] idx;   // selected beat when done == 0
    } beat_sel_t;

    // Lowest beat index >= k whose mask pair is nonzero. k is 4 bits so that
    // "one past the last beat" (8) can be passed in and yields done.
    function automatic beat_sel_t next_beat(input logic [15:0] mask16, input logic [3:0] k);
        beat_sel_t r;
        r.done = 1'b1;
        r.idx  = 3'd0;
        // Descending scan so the lowest qualifying index is the one kept.
        for (int i = BG_BEATS - 1; i >= 0; i--) begin
            if ((4'(i) >= k) && (mask16[2*i +: 2] != 2'b00)) begin
                r.done = 1'b0;
                r.idx  = 3'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] beat_word(input logic [255:0] blk, input logic [2:0] k);
        return blk[{k, 5'd0} +: 32];
    endfunction

    function automatic logic [1:0] beat_mask(input logic [15:0] mask16, input logic [2:0] k);
        return mask16[{k, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/gpu_bg_block_mem.sv
// Background-block memory sequencer between the pixel backend and the memory
// arbiter. On a pair code it writes back the finished block (masked beats only),
// reads the next block, presents it to the backend for one cycle and pulses the
// pipeline mask/state resets.
//
// Ports:
//   clk, i_nrst                     clock, async active-low reset
//   i_saveBGBlock[1:0]              pair code (none/first/next/flush)
//   i_saveAdr, i_loadAdr [14:0]     block addresses for write-back / load
//   i_exportedBGBlock[255:0]        finished block pixels
//   i_exportedMSKBGBlock[15:0]      per-pixel written flags
//   o_pausePipeline                 combinational freeze request
//   o_resetPipelinePixelStateSpike  clears the backend pair code
//   o_resetPixelMask                clears the backend mask
//   o_importBGBlockSingleClock      o_importedBGBlock valid this cycle
//   o_importedBGBlock[255:0]        loaded block buffer
//   o_flushDone                     end of a flush sequence
//   o_memReq/o_memWrite/o_memAdr/o_memWdata/o_memWmask, i_memAck
//                                   request channel, held until ack
//   i_memRdValid, i_memRdata        in-order read beats 0..7
module gpu_bg_block_mem
    import gpu_bg_pkg::*;
(
    input  logic         clk,
    input  logic         i_nrst,
    input  logic [1:0]   i_saveBGBlock,
    input  logic [14:0]  i_saveAdr,
    input  logic [14:0]  i_loadAdr,
    input  logic [255:0] i_exportedBGBlock,
    input  logic [15:0]  i_exportedMSKBGBlock,
    output logic         o_pausePipeline,
    output logic         o_resetPipelinePixelStateSpike,
    output logic         o_resetPixelMask,
    output logic         o_importBGBlockSingleClock,
    output logic [255:0] o_importedBGBlock,
    output logic         o_flushDone,
    output logic         o_memReq,
    output logic         o_memWrite,
    output logic [17:0]  o_memAdr,
    output logic [31:0]  o_memWdata,
    output logic [1:0]   o_memWmask,
    input  logic         i_memAck,
    input  logic         i_memRdValid,
    input  logic [31:0]  i_memRdata
);

    bg_state_e    state_q, state_d;
    logic [1:0]   code_q, code_d;
    logic [14:0]  save_adr_q, save_adr_d;
    logic [14:0]  load_adr_q, load_adr_d;
    logic [2:0]   beat_q, beat_d;
    logic [2:0]   rd_cnt_q, rd_cnt_d;
    logic [255:0] buf_q, buf_d;
    logic         req_q, req_d;
    logic         write_q, write_d;
    logic [17:0]  adr_q, adr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [1:0]   wmask_q, wmask_d;
    logic         mask_rst_q, mask_rst_d;
    logic         import_q, import_d;
    logic         flush_q, flush_d;
    logic         spike_q, spike_d;
    beat_sel_t    sel;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        save_adr_d = save_adr_q;
        load_adr_d = load_adr_q;
        beat_d     = beat_q;
        rd_cnt_d   = rd_cnt_q;
        buf_d      = buf_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        sel        = '0;

        unique case (state_q)
            StIdle: begin
                if (i_saveBGBlock != BG_NONE) begin
                    code_d     = i_saveBGBlock;
                    save_adr_d = i_saveAdr;
                    load_adr_d = i_loadAdr;
                    sel        = next_beat(i_exportedMSKBGBlock, 4'd0);
                    // Request fields come from the live inputs: the capture
                    // registers only hold them from the next cycle on.
                    if (i_saveBGBlock == BG_FIRST) begin
                        state_d = StRdReq;
                        adr_d   = {i_loadAdr, 3'b000};
                    end else if (!sel.done) begin
                        state_d = StWrBeat;
                        beat_d  = sel.idx;
                        adr_d   = {i_saveAdr, sel.idx};
                        wdata_d = beat_word(i_exportedBGBlock, sel.idx);
                        wmask_d = beat_mask(i_exportedMSKBGBlock, sel.idx);
                    end else if (i_saveBGBlock == BG_NEXT) begin
                        state_d = StRdReq;
                        adr_d   = {i_loadAdr, 3'b000};
                    end else begin
                        state_d = StCommit;
                    end
                end
            end
            StWrBeat: begin
                if (i_memAck) begin
                    sel = next_beat(i_exportedMSKBGBlock, {1'b0, beat_q} + 4'd1);
                    if (!sel.done) begin
                        beat_d  = sel.idx;
                        adr_d   = {save_adr_q, sel.idx};
                        wdata_d = beat_word(i_exportedBGBlock, sel.idx);
                        wmask_d = beat_mask(i_exportedMSKBGBlock, sel.idx);
                    end else if (code_q == BG_NEXT) begin
                        state_d = StRdReq;
                        adr_d   = {load_adr_q, 3'b000};
                    end else begin
                        state_d = StCommit;
                    end
                end
            end
            StRdReq: begin
                if (i_memAck) begin
                    state_d  = StRdData;
                    rd_cnt_d = 3'd0;
                end
            end
            StRdData: begin
                if (i_memRdValid) begin
                    buf_d[{rd_cnt_q, 5'd0} +: 32] = i_memRdata;
                    rd_cnt_d = rd_cnt_q + 3'd1;
                    if (rd_cnt_q == 3'(BG_BEATS - 1)) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit:  state_d = StRelease;
            StRelease: state_d = StHold;
            StHold:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        // Outputs are registered, so each is decoded from the state being entered.
        req_d      = (state_d == StWrBeat) || (state_d == StRdReq);
        write_d    = (state_d == StWrBeat);
        mask_rst_d = (state_d == StCommit);
        import_d   = (state_d == StCommit) && (code_d != BG_FLUSH);
        flush_d    = (state_d == StCommit) && (code_d == BG_FLUSH);
        spike_d    = (state_d == StRelease);
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= StIdle;
            code_q     <= BG_NONE;
            save_adr_q <= '0;
            load_adr_q <= '0;
            beat_q     <= '0;
            rd_cnt_q   <= '0;
            buf_q      <= '0;
            req_q      <= 1'b0;
            write_q    <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            mask_rst_q <= 1'b0;
            import_q   <= 1'b0;
            flush_q    <= 1'b0;
            spike_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            save_adr_q <= save_adr_d;
            load_adr_q <= load_adr_d;
            beat_q     <= beat_d;
            rd_cnt_q   <= rd_cnt_d;
            buf_q      <= buf_d;
            req_q      <= req_d;
            write_q    <= write_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            mask_rst_q <= mask_rst_d;
            import_q   <= import_d;
            flush_q    <= flush_d;
            spike_q    <= spike_d;
        end
    end

    assign o_pausePipeline                = (state_q != StIdle) || (i_saveBGBlock != BG_NONE);
    assign o_resetPipelinePixelStateSpike = spike_q;
    assign o_resetPixelMask               = mask_rst_q;
    assign o_importBGBlockSingleClock     = import_q;
    assign o_importedBGBlock              = buf_q;
    assign o_flushDone                    = flush_q;
    assign o_memReq                       = req_q;
    assign o_memWrite                     = write_q;
    assign o_memAdr                       = adr_q;
    assign o_memWdata                     = wdata_q;
    assign o_memWmask                     = wmask_q;

endmodule

// File: tb/tb_gpu_bg_block_mem.sv
// Directed bench for gpu_bg_block_mem: idle-based sequences for codes 01/10/11,
// masked write-back beat selection, withheld ack, and asynchronous reset.
module tb_gpu_bg_block_mem;

    logic         clk = 1'b0;
    logic         nrst;
    logic [1:0]   code;
    logic [14:0]  save_adr, load_adr;
    logic [255:0] blk;
    logic [15:0]  msk;
    logic         ack, rdvalid;
    logic [31:0]  rdata;

    logic         pause, spike, mask_rst, imp, flush_done;
    logic [255:0] imported;
    logic         req, wr;
    logic [17:0]  adr;
    logic [31:0]  wdata;
    logic [1:0]   wmask;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int req_cyc  = 0;
    int c0, w0, r0;

    gpu_bg_block_mem dut (
        .clk                            (clk),
        .i_nrst                         (nrst),
        .i_saveBGBlock                  (code),
        .i_saveAdr                      (save_adr),
        .i_loadAdr                      (load_adr),
        .i_exportedBGBlock              (blk),
        .i_exportedMSKBGBlock           (msk),
        .o_pausePipeline                (pause),
        .o_resetPipelinePixelStateSpike (spike),
        .o_resetPixelMask               (mask_rst),
        .o_importBGBlockSingleClock     (imp),
        .o_importedBGBlock              (imported),
        .o_flushDone                    (flush_done),
        .o_memReq                       (req),
        .o_memWrite                     (wr),
        .o_memAdr                       (adr),
        .o_memWdata                     (wdata),
        .o_memWmask                     (wmask),
        .i_memAck                       (ack),
        .i_memRdValid                   (rdvalid),
        .i_memRdata                     (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req) req_cyc <= req_cyc + 1;
        if (req && wr && ack) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Block whose word k is base + k.
    function automatic logic [255:0] exp_block(input logic [31:0] base);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[32*k +: 32] = base + 32'(k);
        return b;
    endfunction

    task automatic read_burst(input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            rdvalid = 1'b1;
            rdata   = base + 32'(k);
            tick();
        end
        rdvalid = 1'b0;
        rdata   = '0;
    endtask

    task automatic ack_once();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; code = 2'b00; save_adr = '0; load_adr = '0;
        ack = 1'b0; rdvalid = 1'b0; rdata = '0; msk = '0;
        for (int k = 0; k < 8; k++) blk[32*k +: 32] = 32'hCAFE_0000 + 32'(k);
        tick();
        tick();
        chk("rst_req", req, 0);
        chk("rst_imported", imported, 0);
        chk("rst_pause", pause, 0);
        chk("rst_pulses", {spike, mask_rst, imp, flush_done}, 0);
        chk("rst_adr", adr, 0);
        nrst = 1'b1;
        tick();

        // Code 01: load only.
        code = 2'b01; load_adr = 15'h1234;
        #1 chk("t1_pause_same_cycle", pause, 1);
        tick(); c0 = cyc; code = 2'b00;
        chk("t1_rd_req", {req, wr}, 2'b10);
        chk("t1_rd_adr", adr, 18'h091A0);
        chk("t1_pause_busy", pause, 1);
        ack_once();
        chk("t1_req_dropped", req, 0);
        read_burst(32'h0);
        chk("t1_commit_pulses", {imp, mask_rst, flush_done, spike}, 4'b1100);
        chk("t1_block", imported,
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        tick();
        chk("t1_release", {imp, mask_rst, spike}, 3'b001);
        tick();
        chk("t1_hold_pause", pause, 1);
        tick();
        chk("t1_idle_pause", pause, 0);
        chk("t1_latency", cyc - c0, 12);

        // Code 10, mask 0x0003: single full-word write, then load.
        code = 2'b10; msk = 16'h0003; save_adr = 15'h0010; load_adr = 15'h0020;
        w0 = wr_cnt;
        tick(); code = 2'b00;
        chk("t2_wr_req", {req, wr}, 2'b11);
        chk("t2_wr_adr", adr, 18'h00080);
        chk("t2_wr_mask", wmask, 2'b11);
        chk("t2_wr_data", wdata, 32'hCAFE0000);
        ack_once();
        chk("t2_rd_req", {req, wr}, 2'b10);
        chk("t2_rd_adr", adr, 18'h00100);
        chk("t2_write_count", wr_cnt - w0, 1);
        ack_once();
        read_burst(32'h100);
        chk("t2_import", {imp, flush_done}, 2'b10);
        chk("t2_block", imported, exp_block(32'h100));
        tick(); tick(); tick();
        chk("t2_idle_pause", pause, 0);

        // Code 10, mask 0x8001, first ack withheld 5 cycles.
        code = 2'b10; msk = 16'h8001; save_adr = 15'h7FFF; load_adr = 15'h0001;
        w0 = wr_cnt;
        tick(); code = 2'b00;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_req", {req, wr, pause}, 3'b111);
            chk("t3_stall_adr", adr, 18'h3FFF8);
            chk("t3_stall_mask", wmask, 2'b01);
            chk("t3_stall_data", wdata, 32'hCAFE0000);
            tick();
        end
        ack_once();
        chk("t3_beat7_req", {req, wr}, 2'b11);
        chk("t3_beat7_adr", adr, 18'h3FFFF);
        chk("t3_beat7_mask", wmask, 2'b10);
        chk("t3_beat7_data", wdata, 32'hCAFE0007);
        ack_once();
        chk("t3_rd_req", {req, wr}, 2'b10);
        chk("t3_rd_adr", adr, 18'h00008);
        chk("t3_write_count", wr_cnt - w0, 2);
        ack_once();
        read_burst(32'h200);
        chk("t3_block", imported, exp_block(32'h200));
        chk("t3_import", imp, 1);
        tick(); tick(); tick();
        chk("t3_idle_pause", pause, 0);

        // Code 11 with empty mask: no traffic, flush pulse only.
        code = 2'b11; msk = 16'h0000;
        r0 = req_cyc;
        tick(); c0 = cyc;
        chk("t4_commit", {flush_done, mask_rst, imp, req}, 4'b1100);
        code = 2'b00;
        tick();
        chk("t4_release", {spike, flush_done}, 2'b10);
        tick();
        chk("t4_hold_pause", pause, 1);
        tick();
        chk("t4_idle_pause", pause, 0);
        chk("t4_no_traffic", req_cyc - r0, 0);
        chk("t4_latency", cyc - c0, 3);
        chk("t4_block_kept", imported, exp_block(32'h200));

        // Reset during RD_DATA after 4 beats.
        code = 2'b01; load_adr = 15'h0005;
        tick(); code = 2'b00;
        ack_once();
        for (int k = 0; k < 4; k++) begin
            rdvalid = 1'b1;
            rdata   = 32'h300 + 32'(k);
            tick();
        end
        #2 nrst = 1'b0;
        #1;
        chk("t6_async_req", {req, wr}, 0);
        chk("t6_async_imported", imported, 0);
        chk("t6_async_pulses", {spike, mask_rst, imp, flush_done, pause}, 0);
        tick(); tick();
        nrst = 1'b1;
        for (int k = 4; k < 8; k++) begin
            rdata = 32'h300 + 32'(k);
            tick();
            chk("t6_late_beat_ignored", {imported, imp}, 0);
        end
        rdvalid = 1'b0;
        code = 2'b01; load_adr = 15'h0002;
        tick(); code = 2'b00;
        chk("t6_restart_adr", adr, 18'h00010);
        ack_once();
        read_burst(32'h400);
        chk("t6_restart_block", imported, exp_block(32'h400));
        chk("t6_restart_import", imp, 1);
        tick(); tick(); tick();
        chk("t6_idle_pause", pause, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
